// File: rtl/control_fsm_pkg.sv
// Shared constants for the instruction-sequencing control FSM: opcodes, condition
// codes, state encoding, write-back selects and instruction classes.
package control_fsm_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_MISC  = 4'b0100;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] CC_EQ  = 4'b0000;
    localparam logic [3:0] CC_NE  = 4'b0001;
    localparam logic [3:0] CC_CS  = 4'b0010;
    localparam logic [3:0] CC_CC  = 4'b0011;
    localparam logic [3:0] CC_HI  = 4'b0100;
    localparam logic [3:0] CC_LS  = 4'b0101;
    localparam logic [3:0] CC_GT  = 4'b0110;
    localparam logic [3:0] CC_LE  = 4'b0111;
    localparam logic [3:0] CC_FS  = 4'b1000;
    localparam logic [3:0] CC_FC  = 4'b1001;
    localparam logic [3:0] CC_LO  = 4'b1010;
    localparam logic [3:0] CC_HS  = 4'b1011;
    localparam logic [3:0] CC_LT  = 4'b1100;
    localparam logic [3:0] CC_GE  = 4'b1101;
    localparam logic [3:0] CC_UC  = 4'b1110;
    localparam logic [3:0] CC_JAL = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_PCUPD  = 3'd5
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [2:0] IC_ALU   = 3'd0;
    localparam logic [2:0] IC_CMP   = 3'd1;
    localparam logic [2:0] IC_LOAD  = 3'd2;
    localparam logic [2:0] IC_STOR  = 3'd3;
    localparam logic [2:0] IC_BCOND = 3'd4;
    localparam logic [2:0] IC_JCOND = 3'd5;
    localparam logic [2:0] IC_JAL   = 3'd6;
    localparam logic [2:0] IC_UNDEF = 3'd7;

endpackage

// File: rtl/control_fsm_instr_decode.sv
// Combinational instruction classifier (opcode/ext -> class).
// TRON_JAL_EN defined: opcode 0100 ext 1000 decodes as JAL; otherwise it is undefined.
module instr_decode
    import control_fsm_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [3:0] i_ext,
    output logic [2:0] o_class
);

    always_comb begin
        o_class = IC_ALU;
        if (i_opcode == OP_MISC) begin
            case (i_ext)
                EXT_LOAD:  o_class = IC_LOAD;
                EXT_STOR:  o_class = IC_STOR;
                EXT_JCOND: o_class = IC_JCOND;
`ifdef TRON_JAL_EN
                EXT_JAL:   o_class = IC_JAL;
`else
                EXT_JAL:   o_class = IC_UNDEF;
`endif
                default:   o_class = IC_UNDEF;
            endcase
        end else if (i_opcode == OP_BCOND) begin
            o_class = IC_BCOND;
        end else if (i_opcode == OP_CMPI || (i_opcode == OP_REG && i_ext == EXT_CMP)) begin
            o_class = IC_CMP;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Instruction sequencing FSM: IDLE -> FETCH -> DECODE -> (EXEC | MEM) -> PCUPD.
// TRON_JAL_EN (in instr_decode) enables JAL with link write-back and flag_op=1111 in PCUPD.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [WIDTH-1:0] ir,
    output logic [3:0]       flag_op,
    output logic [WIDTH-1:0] immediate,
    output logic             pc_add,
    output logic             pc_branch,
    output logic             pc_jump,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             flag_write,
    output logic [2:0]       state
);

    state_t           r_state;
    logic [WIDTH-1:0] r_ir;
    logic             r_mem_req;
    logic             r_mem_we;
    logic             r_mem_addr_sel;
    logic             r_reg_write;
    logic [1:0]       r_wb_sel;
    logic             r_flag_write;
    logic             r_pc_add;
    logic             r_pc_branch;
    logic             r_pc_jump;
    logic             r_flag_jal;
    logic [2:0]       w_class;
    logic             w_load_wr;

    instr_decode u_decode (
        .i_opcode (r_ir[15:12]),
        .i_ext    (r_ir[7:4]),
        .o_class  (w_class)
    );

    // Memory handshake: mem_req (with mem_we/mem_addr_sel) rises on entry to FETCH or MEM
    // and is held unchanged until a cycle with mem_ready; the transfer completes on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ir           <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr_sel <= 1'b0;
            r_reg_write    <= 1'b0;
            r_wb_sel       <= WB_ALU;
            r_flag_write   <= 1'b0;
            r_pc_add       <= 1'b0;
            r_pc_branch    <= 1'b0;
            r_pc_jump      <= 1'b0;
            r_flag_jal     <= 1'b0;
        end else begin
            r_reg_write  <= 1'b0;
            r_wb_sel     <= WB_ALU;
            r_flag_write <= 1'b0;
            r_pc_add     <= 1'b0;
            r_pc_branch  <= 1'b0;
            r_pc_jump    <= 1'b0;
            r_flag_jal   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state        <= S_FETCH;
                        r_mem_req      <= 1'b1;
                        r_mem_we       <= 1'b0;
                        r_mem_addr_sel <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir      <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_class)
                        IC_LOAD, IC_STOR: begin
                            r_state        <= S_MEM;
                            r_mem_req      <= 1'b1;
                            r_mem_addr_sel <= 1'b1;
                            r_mem_we       <= (w_class == IC_STOR);
                        end
                        IC_BCOND: begin
                            r_state     <= S_PCUPD;
                            r_pc_branch <= 1'b1;
                        end
                        IC_JCOND: begin
                            r_state   <= S_PCUPD;
                            r_pc_jump <= 1'b1;
                        end
                        IC_JAL: begin
                            r_state     <= S_PCUPD;
                            r_pc_jump   <= 1'b1;
                            r_reg_write <= 1'b1;
                            r_wb_sel    <= WB_LINK;
                            r_flag_jal  <= 1'b1;
                        end
                        IC_UNDEF: begin
                            r_state  <= S_PCUPD;
                            r_pc_add <= 1'b1;
                        end
                        default: begin
                            r_state      <= S_EXEC;
                            r_reg_write  <= (w_class != IC_CMP);
                            r_flag_write <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    r_state  <= S_PCUPD;
                    r_pc_add <= 1'b1;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_mem_req      <= 1'b0;
                        r_mem_we       <= 1'b0;
                        r_mem_addr_sel <= 1'b0;
                        r_pc_add       <= 1'b1;
                        r_state        <= S_PCUPD;
                    end
                end
                S_PCUPD: begin
                    if (run) begin
                        r_state        <= S_FETCH;
                        r_mem_req      <= 1'b1;
                        r_mem_we       <= 1'b0;
                        r_mem_addr_sel <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_mem_req      <= 1'b0;
                    r_mem_we       <= 1'b0;
                    r_mem_addr_sel <= 1'b0;
                end
            endcase
        end
    end

    // Load write-back must coincide with the mem_ready cycle, so it cannot be registered.
    assign w_load_wr = (r_state == S_MEM) && (w_class == IC_LOAD) && mem_ready;

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr_sel = r_mem_addr_sel;
    assign ir           = r_ir;
    assign flag_op      = r_flag_jal ? CC_JAL : r_ir[11:8];
    assign immediate    = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
    assign pc_add       = r_pc_add;
    assign pc_branch    = r_pc_branch;
    assign pc_jump      = r_pc_jump;
    assign reg_write    = r_reg_write | w_load_wr;
    assign wb_sel       = w_load_wr ? WB_MEM : r_wb_sel;
    assign flag_write   = r_flag_write;
    assign state        = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction cycle traces queued up front, compared cycle by cycle.
`timescale 1ns/1ps
module tb_control_fsm;

    localparam int W = 17;

    localparam int K_ALU   = 0;
    localparam int K_CMP   = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STOR  = 3;
    localparam int K_BR    = 4;
    localparam int K_JMP   = 5;
    localparam int K_JAL   = 6;
    localparam int K_UNDEF = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic [15:0] ir;
    logic [3:0]  flag_op;
    logic [15:0] immediate;
    logic        pc_add;
    logic        pc_branch;
    logic        pc_jump;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        flag_write;
    logic [2:0]  state;

    control_fsm #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir           (ir),
        .flag_op      (flag_op),
        .immediate    (immediate),
        .pc_add       (pc_add),
        .pc_branch    (pc_branch),
        .pc_jump      (pc_jump),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .flag_write   (flag_write),
        .state        (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [W-1:0] obs;
    assign obs = {state, mem_req, mem_we, mem_addr_sel, reg_write, flag_write, wb_sel,
                  pc_add, pc_branch, pc_jump, flag_op};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    logic         rdy_q[$];
    logic         run_q[$];
    logic [15:0]  prev_ir;
    logic         from_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [2:0] st, input logic req, input logic we,
                                        input logic asel, input logic rw, input logic fw,
                                        input logic [1:0] wb, input logic pa, input logic pb,
                                        input logic pj, input logic [3:0] fo);
        return {st, req, we, asel, rw, fw, wb, pa, pb, pj, fo};
    endfunction

    function automatic int ref_kind(input logic [15:0] ins);
        logic [3:0] op;
        logic [3:0] ext;
        op  = ins[15:12];
        ext = ins[7:4];
        if (op == 4'h4) begin
            if (ext == 4'h0)      return K_LOAD;
            else if (ext == 4'h4) return K_STOR;
            else if (ext == 4'hC) return K_JMP;
`ifdef TRON_JAL_EN
            else if (ext == 4'h8) return K_JAL;
`endif
            else                  return K_UNDEF;
        end
        if (op == 4'hC) return K_BR;
        if (op == 4'hB || (op == 4'h0 && ext == 4'hB)) return K_CMP;
        return K_ALU;
    endfunction

    // driver tasks
    task automatic push(input logic [W-1:0] v, input logic rdy, input logic rn);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
        run_q.push_back(rn);
    endtask

    task automatic queue_idle(input int n);
        for (int k = 0; k < n; k++)
            push(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, prev_ir[11:8]), 1'b0, 1'b0);
        from_idle = 1'b1;
    endtask

    task automatic queue_instr(input logic [15:0] ins, input int fwait, input int mwait,
                               input bit drop_run);
        int         kind;
        logic       rn;
        logic [3:0] fo;
        kind = ref_kind(ins);
        fo   = ins[11:8];
        rn   = !drop_run;
        if (from_idle)
            push(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, prev_ir[11:8]), 1'b0, 1'b1);
        for (int k = 0; k < fwait; k++)
            push(mk(3'd1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, prev_ir[11:8]), 1'b0, 1'b1);
        push(mk(3'd1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, prev_ir[11:8]), 1'b1, 1'b1);
        push(mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, fo), 1'b0, 1'b1);
        if (kind == K_ALU || kind == K_CMP)
            push(mk(3'd3, 0, 0, 0, kind == K_ALU, 1, 2'd0, 0, 0, 0, fo), 1'b0, rn);
        if (kind == K_LOAD || kind == K_STOR) begin
            for (int k = 0; k < mwait; k++)
                push(mk(3'd4, 1, kind == K_STOR, 1, 0, 0, 2'd0, 0, 0, 0, fo), 1'b0, rn);
            push(mk(3'd4, 1, kind == K_STOR, 1, kind == K_LOAD, 0,
                    (kind == K_LOAD) ? 2'd1 : 2'd0, 0, 0, 0, fo), 1'b1, rn);
        end
        push(mk(3'd5, 0, 0, 0, kind == K_JAL, 0, (kind == K_JAL) ? 2'd2 : 2'd0,
                !(kind == K_BR || kind == K_JMP || kind == K_JAL), kind == K_BR,
                kind == K_JMP || kind == K_JAL, (kind == K_JAL) ? 4'hF : fo), 1'b0, rn);
        from_idle = drop_run;
        prev_ir   = ins;
    endtask

    // scoreboard: pop one expected vector per cycle, data bus only valid during FETCH
    task automatic drain(input logic [15:0] ins);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e         = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            run       = run_q.pop_front();
            mem_rdata = (e[W-1:W-3] == 3'd1) ? ins : 16'($urandom);
            #1;
            check($sformatf("cyc%0d_ir%h", cyc, ins), 32'(obs), 32'(e));
            cyc++;
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, input int fwait, input int mwait,
                             input bit drop_run);
        queue_instr(ins, fwait, mwait, drop_run);
        drain(ins);
        check("ir", 32'(ir), 32'(ins));
        check("imm", 32'(immediate), 32'({{8{ins[7]}}, ins[7:0]}));
    endtask

    initial begin
        logic [15:0] ins;
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        prev_ir   = 16'h0;
        from_idle = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_vec", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 4'h0)));
        check("rst_ir", 32'(ir), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(16'h0512, 0, 0, 0);
        run_instr(16'hC0FE, 0, 0, 0);
        check("beq_flag_op", 32'(flag_op), 32'h0);
        run_instr(16'h4203, 0, 3, 0);
        run_instr(16'h4140, 2, 1, 0);
        run_instr(16'h4EC3, 1, 0, 0);
        run_instr(16'h03B4, 0, 0, 0);
        run_instr(16'hB305, 0, 0, 0);
        run_instr(16'h4E85, 0, 0, 0);
        run_instr(16'h4F20, 0, 0, 0);
        run_instr(16'h1234, 0, 0, 1);
        queue_idle(2);
        drain(prev_ir);
        run_instr(16'h4203, 1, 2, 1);
        queue_idle(1);
        drain(prev_ir);
        for (int n = 0; n < 12; n++) begin
            ins = 16'($urandom);
            if (n % 3 == 0) ins[15:12] = 4'h4;
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        // reset while a fetch is outstanding
        if (from_idle)
            push(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, prev_ir[11:8]), 1'b0, 1'b1);
        push(mk(3'd1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, prev_ir[11:8]), 1'b0, 1'b1);
        push(mk(3'd1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, prev_ir[11:8]), 1'b0, 1'b1);
        drain(16'hA5A5);
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_ir", 32'(ir), 32'h0);
        @(negedge clk);
        #1;
        check("rst_fetch_vec", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 4'h0)));
        check("rst_fetch_ir", 32'(ir), 32'h0);
        reset     = 1'b0;
        run       = 1'b0;
        prev_ir   = 16'h0;
        from_idle = 1'b1;
        run_instr(16'h0512, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
